// File: rtl/ula_seq_slice_if.sv
// Valid/ready command and result bundle for the sequential slice ALU.
interface ula_seq_slice_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             a_eq_b;
  logic             zero;

  modport master (
    output in_valid, a, b, s, m, c_in, out_ready,
    input  in_ready, out_valid, f, c_out, a_eq_b, zero
  );

  modport slave (
    input  in_valid, a, b, s, m, c_in, out_ready,
    output in_ready, out_valid, f, c_out, a_eq_b, zero
  );
endinterface

// File: rtl/ula_seq_slice.sv
// 74181-style ALU evaluated one 4-bit slice per clock across a WIDTH-bit word,
// with valid/ready handshakes on command and result.
module ula_seq_slice #(
  parameter int unsigned WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  ula_seq_slice_if.slave  bus
);
  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("ula_seq_slice: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, stage_q, stage_next;
  logic [3:0]       s_q;
  logic             m_q, carry_q, eq_q;
  logic [WIDTH-1:0] f_q;
  logic             c_out_q, a_eq_b_q, zero_q;
  logic [3:0]       sa, sb, x, y, lres, slice_f;
  logic [4:0]       sum5;
  logic             slice_c;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid && in_ready_q) state_d = RUN;
      RUN:     if (cnt_q == CW'(NSLICE - 1))   state_d = DONE;
      DONE:    if (bus.out_ready)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs, registered from the next state
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == IDLE) in_ready_d  = 1'b1;
    if (state_d == DONE) out_valid_d = 1'b1;
  end

  // one 4-bit slice of the function table
  always_comb begin
    sa   = a_sh_q[3:0];
    sb   = b_sh_q[3:0];
    x    = 4'h0;
    y    = 4'h0;
    lres = 4'h0;
    case (s_q)
      4'h0: begin lres = ~sa;        x = sa;        y = 4'hF;      end
      4'h1: begin lres = ~(sa | sb); x = sa;        y = sb;        end
      4'h2: begin lres = ~sa & sb;   x = sa;        y = ~sb;       end
      4'h3: begin lres = 4'h0;       x = 4'h0;      y = 4'hF;      end
      4'h4: begin lres = ~(sa & sb); x = sa;        y = sa & ~sb;  end
      4'h5: begin lres = ~sb;        x = sa | sb;   y = sa & ~sb;  end
      4'h6: begin lres = sa ^ sb;    x = sa;        y = ~sb;       end
      4'h7: begin lres = sa & ~sb;   x = sa & ~sb;  y = 4'hF;      end
      4'h8: begin lres = ~sa | sb;   x = sa;        y = sa & sb;   end
      4'h9: begin lres = ~(sa ^ sb); x = sa;        y = sb;        end
      4'hA: begin lres = sb;         x = sa | ~sb;  y = sa & sb;   end
      4'hB: begin lres = sa & sb;    x = sa & sb;   y = 4'hF;      end
      4'hC: begin lres = 4'hF;       x = sa;        y = sa;        end
      4'hD: begin lres = sa | ~sb;   x = sa | sb;   y = sa;        end
      4'hE: begin lres = sa | sb;    x = sa | ~sb;  y = sa;        end
      default: begin lres = sa;      x = sa;        y = 4'hF;      end
    endcase
    sum5       = {1'b0, x} + {1'b0, y} + 5'(carry_q);
    slice_f    = m_q ? lres : sum5[3:0];
    slice_c    = m_q ? 1'b0 : sum5[4];
    stage_next = (stage_q >> 4) | (WIDTH'(slice_f) << (WIDTH - 4));
  end

  // operand capture, slice sweep and result publication on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      c_out_q     <= 1'b0;
      a_eq_b_q    <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      stage_q     <= '0;
      s_q         <= 4'h0;
      m_q         <= 1'b0;
      carry_q     <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      if (state_q == IDLE && state_d == RUN) begin
        a_sh_q  <= bus.a;
        b_sh_q  <= bus.b;
        s_q     <= bus.s;
        m_q     <= bus.m;
        carry_q <= bus.c_in;
        eq_q    <= (bus.a == bus.b);
        cnt_q   <= '0;
      end
      if (state_q == RUN) begin
        a_sh_q  <= a_sh_q >> 4;
        b_sh_q  <= b_sh_q >> 4;
        carry_q <= slice_c;
        stage_q <= stage_next;
        cnt_q   <= cnt_q + CW'(1);
        if (state_d == DONE) begin
          f_q      <= stage_next;
          c_out_q  <= slice_c;
          zero_q   <= (stage_next == '0);
          a_eq_b_q <= eq_q;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
  assign bus.c_out     = c_out_q;
  assign bus.a_eq_b    = a_eq_b_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_ula_seq_slice.sv
// Directed-table and random bench for ula_seq_slice at WIDTH 4, 16 and 32.
module tb_ula_seq_slice;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ula_seq_slice_if #(.WIDTH(16)) b16();
  ula_seq_slice_if #(.WIDTH(4))  b4();
  ula_seq_slice_if #(.WIDTH(32)) b32();

  ula_seq_slice #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  ula_seq_slice #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  ula_seq_slice #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // word-level reference of the 32-function table
  function automatic void gold(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                               input logic m, input logic cin, input int w,
                               output logic [31:0] f, output logic co);
    logic [32:0] msk, aa, bb, x, y, r, sum;
    msk = (33'd1 << w) - 33'd1;
    aa  = {1'b0, a} & msk;
    bb  = {1'b0, b} & msk;
    x = '0; y = '0; r = '0; co = 1'b0;
    if (m) begin
      case (s)
        4'h0: r = ~aa;          4'h1: r = ~(aa | bb);
        4'h2: r = ~aa & bb;     4'h3: r = '0;
        4'h4: r = ~(aa & bb);   4'h5: r = ~bb;
        4'h6: r = aa ^ bb;      4'h7: r = aa & ~bb;
        4'h8: r = ~aa | bb;     4'h9: r = ~(aa ^ bb);
        4'hA: r = bb;           4'hB: r = aa & bb;
        4'hC: r = msk;          4'hD: r = aa | ~bb;
        4'hE: r = aa | bb;      default: r = aa;
      endcase
      f = 32'(r & msk);
    end else begin
      case (s)
        4'h0: begin x = aa;       y = msk;      end
        4'h1: begin x = aa;       y = bb;       end
        4'h2: begin x = aa;       y = ~bb;      end
        4'h3: begin x = '0;       y = msk;      end
        4'h4: begin x = aa;       y = aa & ~bb; end
        4'h5: begin x = aa | bb;  y = aa & ~bb; end
        4'h6: begin x = aa;       y = ~bb;      end
        4'h7: begin x = aa & ~bb; y = msk;      end
        4'h8: begin x = aa;       y = aa & bb;  end
        4'h9: begin x = aa;       y = bb;       end
        4'hA: begin x = aa | ~bb; y = aa & bb;  end
        4'hB: begin x = aa & bb;  y = msk;      end
        4'hC: begin x = aa;       y = aa;       end
        4'hD: begin x = aa | bb;  y = aa;       end
        4'hE: begin x = aa | ~bb; y = aa;       end
        default: begin x = aa;    y = msk;      end
      endcase
      sum = (x & msk) + (y & msk) + 33'(cin);
      f   = 32'(sum & msk);
      co  = sum[w];
    end
  endfunction

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                      input logic m, input logic cin,
                      output logic [15:0] f, output logic co, output logic eq,
                      output logic z, output int lat);
    int n;
    @(negedge clk);
    b16.a = a; b16.b = b; b16.s = s; b16.m = m; b16.c_in = cin; b16.in_valid = 1'b1;
    n = 0;
    while (!b16.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!b16.in_ready) chk("w16_accept_timeout", 64'(b16.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    b16.in_valid = 1'b0;
    b16.a = ~a; b16.b = ~b; b16.s = ~s; b16.m = ~m; b16.c_in = ~cin;
    lat = 0;
    while (!b16.out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!b16.out_valid) chk("w16_done_timeout", 64'(b16.out_valid), 64'd1);
    f = b16.f; co = b16.c_out; eq = b16.a_eq_b; z = b16.zero;
    b16.out_ready = 1'b1;
    @(negedge clk);
    b16.out_ready = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                     input logic m, input logic cin, output logic [3:0] f, output logic co);
    int n;
    @(negedge clk);
    b4.a = a; b4.b = b; b4.s = s; b4.m = m; b4.c_in = cin; b4.in_valid = 1'b1;
    n = 0;
    while (!b4.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!b4.in_ready) chk("w4_accept_timeout", 64'(b4.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = 1'b0;
    n = 0;
    while (!b4.out_valid && n < 50) begin @(negedge clk); n++; end
    if (!b4.out_valid) chk("w4_done_timeout", 64'(b4.out_valid), 64'd1);
    f = b4.f; co = b4.c_out;
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                      input logic m, input logic cin, output logic [31:0] f, output logic co);
    int n;
    @(negedge clk);
    b32.a = a; b32.b = b; b32.s = s; b32.m = m; b32.c_in = cin; b32.in_valid = 1'b1;
    n = 0;
    while (!b32.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!b32.in_ready) chk("w32_accept_timeout", 64'(b32.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    b32.in_valid = 1'b0;
    n = 0;
    while (!b32.out_valid && n < 50) begin @(negedge clk); n++; end
    if (!b32.out_valid) chk("w32_done_timeout", 64'(b32.out_valid), 64'd1);
    f = b32.f; co = b32.c_out;
    b32.out_ready = 1'b1;
    @(negedge clk);
    b32.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, cin;
    logic [15:0] f;
    logic        co, eq, z;
  } vec_t;

  initial begin
    vec_t vt[10];
    logic [15:0] f16;
    logic [31:0] gf, ra, rb, f32;
    logic [3:0]  f4, rs;
    logic        co, eq, z, rm, rc, gco;
    int          lat;

    vt[0] = '{16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[1] = '{16'h1234, 16'h0234, 4'h6, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0};
    vt[2] = '{16'h0005, 16'h0000, 4'h0, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0};
    vt[3] = '{16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vt[4] = '{16'hA5A5, 16'hA5A5, 4'h6, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    vt[5] = '{16'h1234, 16'h4321, 4'h1, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
    vt[6] = '{16'h8001, 16'h0000, 4'hC, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    vt[7] = '{16'hF0F0, 16'hFF00, 4'hB, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0};
    vt[8] = '{16'h1234, 16'h5678, 4'h3, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[9] = '{16'h00FF, 16'h0F0F, 4'hA, 1'b0, 1'b0, 16'hF10E, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    b16.in_valid = 1'b1; b16.out_ready = 1'b0;
    b16.a = 16'h1111; b16.b = 16'h2222; b16.s = 4'h1; b16.m = 1'b0; b16.c_in = 1'b0;
    b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.a = '0; b4.b = '0; b4.s = '0; b4.m = 1'b0; b4.c_in = 1'b0;
    b32.in_valid = 1'b0; b32.out_ready = 1'b0; b32.a = '0; b32.b = '0; b32.s = '0; b32.m = 1'b0; b32.c_in = 1'b0;

    // reset held with in_valid asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(b16.in_ready), 64'd0);
    chk("rst_out_valid", 64'(b16.out_valid), 64'd0);
    chk("rst_f", 64'(b16.f), 64'd0);
    chk("rst_flags", 64'({b16.c_out, b16.a_eq_b, b16.zero}), 64'd0);
    rst_n = 1'b1;
    b16.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(b16.in_ready), 64'd1);
    @(negedge clk);
    chk("post_rst_no_accept", 64'(b16.in_ready), 64'd1);

    foreach (vt[i]) begin
      op16(vt[i].a, vt[i].b, vt[i].s, vt[i].m, vt[i].cin, f16, co, eq, z, lat);
      chk($sformatf("vec%0d_f", i), 64'(f16), 64'(vt[i].f));
      chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vt[i].co));
      chk($sformatf("vec%0d_eq", i), 64'(eq), 64'(vt[i].eq));
      chk($sformatf("vec%0d_zero", i), 64'(z), 64'(vt[i].z));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
    end

    for (int code = 0; code < 16; code++) begin
      rc = 1'($urandom_range(0, 1));
      op16(16'h3C5A, 16'h0FF0, 4'(code), 1'b1, rc, f16, co, eq, z, lat);
      gold(32'h3C5A, 32'h0FF0, 4'(code), 1'b1, rc, 16, gf, gco);
      chk($sformatf("logic%0d_f", code), 64'(f16), 64'(gf[15:0]));
      chk($sformatf("logic%0d_cout", code), 64'(co), 64'd0);
    end

    // backpressure: hold DONE while the input side churns
    @(negedge clk);
    b16.a = 16'h1234; b16.b = 16'h1111; b16.s = 4'h9; b16.m = 1'b0; b16.c_in = 1'b0;
    b16.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b16.in_valid = 1'b0;
    lat = 0;
    while (!b16.out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("bp_reached_done", 64'(b16.out_valid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      b16.in_valid = ~b16.in_valid;
      b16.a = 16'($urandom);
      b16.b = 16'($urandom);
      @(negedge clk);
      chk("bp_f", 64'(b16.f), 64'h2345);
      chk("bp_out_valid", 64'(b16.out_valid), 64'd1);
      chk("bp_in_ready", 64'(b16.in_ready), 64'd0);
      chk("bp_flags", 64'({b16.c_out, b16.a_eq_b, b16.zero}), 64'd0);
    end
    b16.in_valid = 1'b0;
    b16.out_ready = 1'b1;
    @(negedge clk);
    b16.out_ready = 1'b0;
    chk("bp_release_valid", 64'(b16.out_valid), 64'd0);
    chk("bp_release_ready", 64'(b16.in_ready), 64'd1);
    chk("bp_idle_keeps_f", 64'(b16.f), 64'h2345);

    // abort: reset lands on E2 of an operation
    b16.a = 16'h0F0F; b16.b = 16'h0101; b16.s = 4'h1; b16.m = 1'b0; b16.c_in = 1'b0;
    b16.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b16.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 64'(b16.out_valid), 64'd0);
    chk("abort_in_ready", 64'(b16.in_ready), 64'd0);
    chk("abort_f", 64'(b16.f), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(b16.out_valid), 64'd0);
    end
    op16(16'h0F0F, 16'h0101, 4'h1, 1'b0, 1'b0, f16, co, eq, z, lat);
    chk("after_abort_f", 64'(f16), 64'h1010);
    chk("after_abort_latency", 64'(lat), 64'd4);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = (i % 8 == 0) ? ra : $urandom; rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
      op16(ra[15:0], rb[15:0], rs, rm, rc, f16, co, eq, z, lat);
      gold(ra, rb, rs, rm, rc, 16, gf, gco);
      chk("rnd16_f", 64'(f16), 64'(gf[15:0]));
      chk("rnd16_cout", 64'(co), 64'(gco));
      chk("rnd16_eq", 64'(eq), 64'(ra[15:0] == rb[15:0]));
      chk("rnd16_zero", 64'(z), 64'(gf[15:0] == 16'h0));
    end
    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom; rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
      op4(ra[3:0], rb[3:0], rs, rm, rc, f4, co);
      gold(ra, rb, rs, rm, rc, 4, gf, gco);
      chk("rnd4_f", 64'(f4), 64'(gf[3:0]));
      chk("rnd4_cout", 64'(co), 64'(gco));
    end
    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom; rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
      op32(ra, rb, rs, rm, rc, f32, co);
      gold(ra, rb, rs, rm, rc, 32, gf, gco);
      chk("rnd32_f", 64'(f32), 64'(gf));
      chk("rnd32_cout", 64'(co), 64'(gco));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
